rob_mc: RTL and testbench
=========================

# rob_mc

Parametrised multi-port reorder buffer for the out-of-order core. It sits between decode/dispatch and the architectural register file/RAT. It allocates one entry per dispatched instruction and accepts results from `CDB_N` completion buses. It serves two source-operand lookups with same-cycle CDB bypass, and retires up to `COMMIT_W` consecutive ready entries per cycle in program order.

## Interface
Parameters:
- `DEPTH`, 16, entry count; power of two, ≥ 4
- `PTR_W`, $clog2(DEPTH), entry index width
- `CDB_N`, 2, number of completion write ports
- `COMMIT_W`, 2, maximum retires per cycle; 1 ≤ `COMMIT_W` ≤ 4

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-low reset
- `disp_valid`  in  1  dispatch request
- `disp_ready`  out  1  entry available
- `disp_inst`  in  32  instruction word
- `disp_pc`  in  32  instruction PC
- `disp_has_rd`  in  1  instruction writes rd
- `disp_id`  out  PTR_W  index allocated on this handshake (= tail)
- `cdb_wr`  in  CDB_N  completion strobe per port
- `cdb_id`  in  CDB_N*PTR_W  target entry per port
- `cdb_wdata`  in  CDB_N*32  result per port
- `lk_id`  in  2*PTR_W  source lookup index (rs1, rs2)
- `lk_ready`  out  2  looked-up value available
- `lk_wdata`  out  64  looked-up value
- `cmt_valid`  out  COMMIT_W  lane k retires this cycle
- `cmt_rd_wr`  out  COMMIT_W  lane k writes GPR
- `cmt_rd`  out  COMMIT_W*5  lane k rd (0 when no write)
- `cmt_wdata`  out  COMMIT_W*32  lane k result
- `cmt_pc`  out  COMMIT_W*32  lane k PC
- `cmt_id`  out  COMMIT_W*PTR_W  lane k entry index
- `flush`  in  1  synchronous squash of all entries
- `count`  out  PTR_W+1  occupied entries
- `empty`  out  1  `count == 0`

## Operation
- Entry state: `valid`, `ready`, `inst`, `pc`, `has_rd`, `wdata`. Head pointer `hptr` and tail pointer `tptr` are PTR_W bits and wrap modulo `DEPTH`. `count` is registered.
- Dispatch: `disp_ready = (count != DEPTH) & ~flush`. On `disp_valid & disp_ready`, entry `tptr` is written with `valid=1` and `ready=0`, and `tptr` increments.
- Completion: for each port p with `cdb_wr[p]`, when entry `cdb_id[p]` is valid, set `ready=1` and capture `wdata`. A write to an invalid entry is ignored. If several ports target the same id in one cycle, the lowest port index wins.
- Lookup, per source s, combinational, in priority order:
  - If the entry is valid and ready: `lk_ready=1`, `lk_wdata` = stored `wdata`.
  - Else if any `cdb_wr[p]` has `cdb_id[p]==lk_id[s]`: `lk_ready=1`, with bypass data from the lowest such port.
  - Else: `lk_ready=0`, `lk_wdata=0`.
- Commit, lane k, combinational: `cmt_valid[k]` is high when entry `hptr+k` is valid and ready, `cmt_valid[k-1]` is high (when k>0), and `flush=0`. `cmt_rd_wr[k] = cmt_valid[k] & has_rd`. All `cmt_*` fields of invalid lanes are 0.
- Retired entries are cleared. `hptr` advances by popcount(`cmt_valid`).
- Counter update: `count_next = count + dispatched - retired`.
- `flush` overrides dispatch, CDB and commit in its cycle. All `valid`/`ready` bits, both pointers and `count` return to 0 on the next edge.

## Timing
- Reset (async assert, sync release): pointers 0, all valid/ready 0, `count` 0.
  - Resulting outputs: `disp_ready=1`, `empty=1`, `cmt_valid=0`, `lk_ready=0`, `disp_id=0`.
- Dispatch→visible: entry is valid from the next cycle.
- CDB→ready: the entry is ready from the next cycle. The earliest commit is one cycle after the CDB write, since there is no CDB→commit bypass.
- CDB→lookup: same cycle, via the bypass.
- Full: at `count==DEPTH`, `disp_ready=0` even if lanes retire that cycle. The freed slots become available the next cycle.
- Simultaneous dispatch and retire: `count` changes by the net amount. The tail may equal the head after wrap only when `count` is 0 or `DEPTH`.
- Reset asserted mid-operation: all state is cleared immediately. In-flight handshakes are lost.

## Configuration
- `ROB_MC_EXC_EN` defined:
  - Adds input `cdb_exc[CDB_N]`, a per-entry `exc` bit captured with the CDB write, and outputs `exc_req` (1) and `exc_pc` (32).
  - An excepting entry at lane k stops retirement: lanes ≥ k are not valid. `exc_req` is asserted with `exc_pc` = that entry's PC only when the entry is at lane 0, and the entry is not committed.
  - `exc_req` stays high until `flush`.
- Undefined: no `exc` storage and no exception ports; every ready entry is retirable.

## Test plan
- Reset, then dispatch PCs 0x100, 0x104, 0x108 → `disp_id` = 0, 1, 2 and `count`=3. CDB writes ids 0 and 1 in the same cycle with 0xA, 0xB → next cycle `cmt_valid`=2'b11, `cmt_wdata`={0xB,0xA}, and `count` becomes 1.
- Out-of-order completion: id 1 becomes ready before id 0 → `cmt_valid`=0 until id 0 is ready, then both lanes retire together.
- Fill to 16 entries → `disp_ready=0`. Retire 2 with `disp_valid` high → no dispatch that cycle; the next dispatch gets `disp_id` at the wrapped index.
- Lookup id 5 (not ready) while port 1 writes id 5 = 0xDEAD → `lk_ready=1`, `lk_wdata=0xDEAD` in the same cycle.
- `flush` with 6 entries and a coincident `disp_valid` → `disp_ready=0`, no allocation; next cycle `count=0`, `empty=1`, `disp_id=0`.
- With `ROB_MC_EXC_EN`, `cdb_exc` is set on the head entry at PC 0x200 → `cmt_valid=0`, `exc_req=1`, `exc_pc=0x200` until `flush`.

Source files
------------

// File: rtl/rob_mc_if.sv
// rob_mc_if: bundles the dispatch, completion, lookup, commit and flush
// signals of the reorder buffer. clk and rst stay plain ports on the module.
// Optional exception signals exist only when ROB_MC_EXC_EN is defined.
interface rob_mc_if #(
  parameter int DEPTH    = 16,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int CDB_N    = 2,
  parameter int COMMIT_W = 2
);
  logic                      disp_valid;
  logic                      disp_ready;
  logic [31:0]               disp_inst;
  logic [31:0]               disp_pc;
  logic                      disp_has_rd;
  logic [PTR_W-1:0]          disp_id;
  logic [CDB_N-1:0]          cdb_wr;
  logic [CDB_N*PTR_W-1:0]    cdb_id;
  logic [CDB_N*32-1:0]       cdb_wdata;
  logic [2*PTR_W-1:0]        lk_id;
  logic [1:0]                lk_ready;
  logic [63:0]               lk_wdata;
  logic [COMMIT_W-1:0]       cmt_valid;
  logic [COMMIT_W-1:0]       cmt_rd_wr;
  logic [COMMIT_W*5-1:0]     cmt_rd;
  logic [COMMIT_W*32-1:0]    cmt_wdata;
  logic [COMMIT_W*32-1:0]    cmt_pc;
  logic [COMMIT_W*PTR_W-1:0] cmt_id;
  logic                      flush;
  logic [PTR_W:0]            count;
  logic                      empty;
`ifdef ROB_MC_EXC_EN
  logic [CDB_N-1:0]          cdb_exc;
  logic                      exc_req;
  logic [31:0]               exc_pc;
`endif

  // The reorder buffer side.
  modport slave (
    input  disp_valid, disp_inst, disp_pc, disp_has_rd,
    output disp_ready, disp_id,
    input  cdb_wr, cdb_id, cdb_wdata,
    input  lk_id,
    output lk_ready, lk_wdata,
    output cmt_valid, cmt_rd_wr, cmt_rd, cmt_wdata, cmt_pc, cmt_id,
    input  flush,
    output count, empty
`ifdef ROB_MC_EXC_EN
    , input cdb_exc,
    output exc_req, exc_pc
`endif
  );

  // The dispatch / execute / retire side.
  modport master (
    output disp_valid, disp_inst, disp_pc, disp_has_rd,
    input  disp_ready, disp_id,
    output cdb_wr, cdb_id, cdb_wdata,
    output lk_id,
    input  lk_ready, lk_wdata,
    input  cmt_valid, cmt_rd_wr, cmt_rd, cmt_wdata, cmt_pc, cmt_id,
    output flush,
    input  count, empty
`ifdef ROB_MC_EXC_EN
    , output cdb_exc,
    input  exc_req, exc_pc
`endif
  );
endinterface

// File: rtl/rob_mc.sv
// rob_mc: multi-port reorder buffer. Allocates one entry per dispatch,
// takes results from CDB_N completion buses, serves two operand lookups
// with same-cycle CDB bypass, and retires up to COMMIT_W ready entries per
// cycle in program order. Define ROB_MC_EXC_EN to add per-entry exception
// tracking that halts retirement at an excepting entry.
module rob_mc #(
  parameter int DEPTH    = 16,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int CDB_N    = 2,
  parameter int COMMIT_W = 2
) (
  input logic     clk,
  input logic     rst,
  rob_mc_if.slave bus
);
  // Control state (reset)
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] rdy_q;
  logic [PTR_W-1:0] hptr_q;
  logic [PTR_W-1:0] tptr_q;
  logic [PTR_W:0]   count_q;
`ifdef ROB_MC_EXC_EN
  logic [DEPTH-1:0] exc_q;
`endif

  // Payload state (never reset; only read while the entry is valid).
  // Only the rd field of the instruction word is consumed at retire.
  logic [31:0]      pc_q    [DEPTH];
  logic [4:0]       rd_q    [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [DEPTH-1:0] has_rd_q;

  logic           disp_rdy;
  logic           disp_fire;
  logic [PTR_W:0] retired;
  logic           unused_inst;

  assign unused_inst = ^{bus.disp_inst[31:12], bus.disp_inst[6:0]};

  assign disp_rdy       = (count_q != (PTR_W+1)'(DEPTH)) & ~bus.flush;
  assign disp_fire      = bus.disp_valid & disp_rdy;
  assign bus.disp_ready = disp_rdy;
  assign bus.disp_id    = tptr_q;
  assign bus.count      = count_q;
  assign bus.empty      = (count_q == '0);

`ifdef ROB_MC_EXC_EN
  // Head entry carries an exception: hold it and request a redirect.
  assign bus.exc_req = vld_q[hptr_q] & rdy_q[hptr_q] & exc_q[hptr_q];
  assign bus.exc_pc  = bus.exc_req ? pc_q[hptr_q] : 32'd0;
`endif

  // Commit lanes: consecutive valid+ready entries from the head.
  always_comb begin
    logic             chain;
    logic [PTR_W-1:0] idx;
    bus.cmt_valid = '0;
    bus.cmt_rd_wr = '0;
    bus.cmt_rd    = '0;
    bus.cmt_wdata = '0;
    bus.cmt_pc    = '0;
    bus.cmt_id    = '0;
    retired       = '0;
    chain         = ~bus.flush;
    idx           = hptr_q;
    for (int k = 0; k < COMMIT_W; k++) begin
      idx   = hptr_q + PTR_W'(k);
`ifdef ROB_MC_EXC_EN
      chain = chain & vld_q[idx] & rdy_q[idx] & ~exc_q[idx];
`else
      chain = chain & vld_q[idx] & rdy_q[idx];
`endif
      if (chain) begin
        bus.cmt_valid[k]               = 1'b1;
        bus.cmt_rd_wr[k]               = has_rd_q[idx];
        bus.cmt_rd[k*5 +: 5]           = has_rd_q[idx] ? rd_q[idx] : 5'd0;
        bus.cmt_wdata[k*32 +: 32]      = wdata_q[idx];
        bus.cmt_pc[k*32 +: 32]         = pc_q[idx];
        bus.cmt_id[k*PTR_W +: PTR_W]   = idx;
        retired                        = retired + (PTR_W+1)'(1);
      end
    end
  end

  // Operand lookup: stored result first, else lowest matching CDB port.
  always_comb begin
    logic [PTR_W-1:0] sid;
    bus.lk_ready = '0;
    bus.lk_wdata = '0;
    sid          = '0;
    for (int s = 0; s < 2; s++) begin
      sid = bus.lk_id[s*PTR_W +: PTR_W];
      if (vld_q[sid] & rdy_q[sid]) begin
        bus.lk_ready[s]          = 1'b1;
        bus.lk_wdata[s*32 +: 32] = wdata_q[sid];
      end else begin
        for (int p = CDB_N-1; p >= 0; p--) begin
          if (bus.cdb_wr[p] && (bus.cdb_id[p*PTR_W +: PTR_W] == sid)) begin
            bus.lk_ready[s]          = 1'b1;
            bus.lk_wdata[s*32 +: 32] = bus.cdb_wdata[p*32 +: 32];
          end
        end
      end
    end
  end

  // Control update: completion, retire clear, allocation, pointers, count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      rdy_q   <= '0;
      hptr_q  <= '0;
      tptr_q  <= '0;
      count_q <= '0;
`ifdef ROB_MC_EXC_EN
      exc_q   <= '0;
`endif
    end else if (bus.flush) begin
      vld_q   <= '0;
      rdy_q   <= '0;
      hptr_q  <= '0;
      tptr_q  <= '0;
      count_q <= '0;
`ifdef ROB_MC_EXC_EN
      exc_q   <= '0;
`endif
    end else begin
      // Descending port order so the lowest port's write lands last.
      for (int p = CDB_N-1; p >= 0; p--) begin
        if (bus.cdb_wr[p] && vld_q[bus.cdb_id[p*PTR_W +: PTR_W]]) begin
          rdy_q[bus.cdb_id[p*PTR_W +: PTR_W]] <= 1'b1;
`ifdef ROB_MC_EXC_EN
          exc_q[bus.cdb_id[p*PTR_W +: PTR_W]] <= bus.cdb_exc[p];
`endif
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (bus.cmt_valid[k]) begin
          vld_q[hptr_q + PTR_W'(k)] <= 1'b0;
          rdy_q[hptr_q + PTR_W'(k)] <= 1'b0;
        end
      end
      if (disp_fire) begin
        vld_q[tptr_q] <= 1'b1;
        rdy_q[tptr_q] <= 1'b0;
`ifdef ROB_MC_EXC_EN
        exc_q[tptr_q] <= 1'b0;
`endif
        tptr_q        <= tptr_q + PTR_W'(1);
      end
      hptr_q  <= hptr_q + retired[PTR_W-1:0];
      count_q <= count_q + (PTR_W+1)'(disp_fire) - retired;
    end
  end

  // Payload capture at dispatch and completion.
  always_ff @(posedge clk) begin
    if (disp_fire) begin
      pc_q[tptr_q]     <= bus.disp_pc;
      rd_q[tptr_q]     <= bus.disp_inst[11:7];
      has_rd_q[tptr_q] <= bus.disp_has_rd;
    end
    for (int p = CDB_N-1; p >= 0; p--) begin
      if (bus.cdb_wr[p] && !bus.flush && vld_q[bus.cdb_id[p*PTR_W +: PTR_W]]) begin
        wdata_q[bus.cdb_id[p*PTR_W +: PTR_W]] <= bus.cdb_wdata[p*32 +: 32];
      end
    end
  end
endmodule

// File: tb/tb_rob_mc.sv
// tb_rob_mc: directed and randomized checks of rob_mc against a queue-based
// program-order model of the reorder buffer.
module tb_rob_mc;
  localparam int DEPTH    = 16;
  localparam int PTR_W    = 4;
  localparam int CDB_N    = 2;
  localparam int COMMIT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rob_mc_if #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CDB_N(CDB_N), .COMMIT_W(COMMIT_W)) bus ();

  rob_mc #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CDB_N(CDB_N), .COMMIT_W(COMMIT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        has_rd;
    logic        rdy;
    logic        exc;
    logic [31:0] wd;
  } ent_t;

  ent_t q[$];
  int   head = 0;
  int   exp_ret = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pos(input int id);
    return (id - head + DEPTH) % DEPTH;
  endfunction

  // Compare every output against the model for the inputs now applied.
  task automatic check_all();
    int n;
    bit go;
    logic [1:0]  er;
    logic [63:0] ed;
    logic [COMMIT_W-1:0]       cv, cw;
    logic [COMMIT_W*5-1:0]     crd;
    logic [COMMIT_W*32-1:0]    cwd, cpc;
    logic [COMMIT_W*PTR_W-1:0] cid;
    n = q.size();
    chk("count", bus.count, n);
    chk("empty", bus.empty, n == 0);
    chk("disp_ready", bus.disp_ready, (n != DEPTH) && !bus.flush);
    chk("disp_id", bus.disp_id, (head + n) % DEPTH);
    er = '0;
    ed = '0;
    for (int s = 0; s < 2; s++) begin
      int id, i;
      bit hit;
      id  = int'(bus.lk_id[s*PTR_W +: PTR_W]);
      i   = pos(id);
      hit = 0;
      if (i < n) begin
        if (q[i].rdy) begin
          er[s] = 1'b1; ed[s*32 +: 32] = q[i].wd; hit = 1;
        end
      end
      for (int p = 0; p < CDB_N; p++) begin
        if (!hit && bus.cdb_wr[p] && int'(bus.cdb_id[p*PTR_W +: PTR_W]) == id) begin
          er[s] = 1'b1; ed[s*32 +: 32] = bus.cdb_wdata[p*32 +: 32]; hit = 1;
        end
      end
    end
    chk("lk_ready", bus.lk_ready, er);
    chk("lk_wdata", bus.lk_wdata, ed);
    cv = '0; cw = '0; crd = '0; cwd = '0; cpc = '0; cid = '0;
    go = !bus.flush;
    exp_ret = 0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (go && k < n) go = q[k].rdy && !q[k].exc;
      else go = 0;
      if (go) begin
        cv[k] = 1'b1;
        cw[k] = q[k].has_rd;
        crd[k*5 +: 5] = q[k].has_rd ? q[k].rd : 5'd0;
        cwd[k*32 +: 32] = q[k].wd;
        cpc[k*32 +: 32] = q[k].pc;
        cid[k*PTR_W +: PTR_W] = PTR_W'((head + k) % DEPTH);
        exp_ret++;
      end
    end
    chk("cmt_valid", bus.cmt_valid, cv);
    chk("cmt_rd_wr", bus.cmt_rd_wr, cw);
    chk("cmt_rd", bus.cmt_rd, crd);
    chk("cmt_wdata", bus.cmt_wdata, cwd);
    chk("cmt_pc", bus.cmt_pc, cpc);
    chk("cmt_id", bus.cmt_id, cid);
`ifdef ROB_MC_EXC_EN
    chk("exc_req", bus.exc_req, (n > 0) && q[0].rdy && q[0].exc);
`endif
  endtask

  // Advance the model by one clock edge using the applied inputs.
  task automatic model_update();
    ent_t e;
    bit fire;
    if (bus.flush) begin
      q.delete();
      head = 0;
      return;
    end
    fire = bus.disp_valid && (q.size() != DEPTH);
    for (int p = CDB_N-1; p >= 0; p--) begin
      if (bus.cdb_wr[p]) begin
        int i;
        i = pos(int'(bus.cdb_id[p*PTR_W +: PTR_W]));
        if (i < q.size()) begin
          e = q[i];
          e.rdy = 1'b1;
          e.wd  = bus.cdb_wdata[p*32 +: 32];
`ifdef ROB_MC_EXC_EN
          e.exc = bus.cdb_exc[p];
`endif
          q[i] = e;
        end
      end
    end
    for (int k = 0; k < exp_ret; k++) void'(q.pop_front());
    head = (head + exp_ret) % DEPTH;
    if (fire) begin
      e.pc = bus.disp_pc;
      e.rd = bus.disp_inst[11:7];
      e.has_rd = bus.disp_has_rd;
      e.rdy = 1'b0;
      e.exc = 1'b0;
      e.wd = 32'd0;
      q.push_back(e);
    end
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
    bus.disp_valid = 1'b0;
    bus.cdb_wr     = '0;
    bus.flush      = 1'b0;
`ifdef ROB_MC_EXC_EN
    bus.cdb_exc    = '0;
`endif
  endtask

  task automatic dispatch(input logic [31:0] pc, input logic [4:0] rd, input logic has_rd);
    bus.disp_valid  = 1'b1;
    bus.disp_pc     = pc;
    bus.disp_inst   = {20'h0, rd, 7'h33};
    bus.disp_has_rd = has_rd;
  endtask

  initial begin
    bus.disp_valid = 1'b0; bus.disp_inst = '0; bus.disp_pc = '0; bus.disp_has_rd = 1'b0;
    bus.cdb_wr = '0; bus.cdb_id = '0; bus.cdb_wdata = '0; bus.lk_id = '0; bus.flush = 1'b0;
`ifdef ROB_MC_EXC_EN
    bus.cdb_exc = '0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset state
    #1;
    chk("rst_disp_ready", bus.disp_ready, 1);
    chk("rst_empty", bus.empty, 1);
    chk("rst_cmt_valid", bus.cmt_valid, 0);
    chk("rst_lk_ready", bus.lk_ready, 0);
    chk("rst_disp_id", bus.disp_id, 0);
    tick();

    // Three dispatches, then ids 0 and 1 complete together
    for (int i = 0; i < 3; i++) begin
      dispatch(32'h100 + 32'(4*i), 5'(i+1), 1'b1);
      #1 chk("a_disp_id", bus.disp_id, i);
      tick();
    end
    #1 chk("a_count3", bus.count, 3);
    bus.cdb_wr = 2'b11; bus.cdb_id = {4'd1, 4'd0}; bus.cdb_wdata = {32'hB, 32'hA};
    tick();
    #1;
    chk("a_cmt_valid", bus.cmt_valid, 2'b11);
    chk("a_cmt_wdata", bus.cmt_wdata, {32'hB, 32'hA});
    chk("a_cmt_pc", bus.cmt_pc, {32'h104, 32'h100});
    tick();
    #1 chk("a_count1", bus.count, 1);

    // Out-of-order completion: id 3 before id 2
    dispatch(32'h10C, 5'd4, 1'b0);
    tick();
    bus.cdb_wr = 2'b01; bus.cdb_id = {4'd0, 4'd3}; bus.cdb_wdata = {32'h0, 32'h33};
    tick();
    #1 chk("b_hold", bus.cmt_valid, 0);
    bus.cdb_wr = 2'b01; bus.cdb_id = {4'd0, 4'd2}; bus.cdb_wdata = {32'h0, 32'h22};
    #1 chk("b_no_bypass", bus.cmt_valid, 0);
    tick();
    #1;
    chk("b_both", bus.cmt_valid, 2'b11);
    chk("b_wdata", bus.cmt_wdata, {32'h33, 32'h22});
    chk("b_rd_wr", bus.cmt_rd_wr, 2'b01);
    tick();

    // Fill to DEPTH, retire two with dispatch pending, then wrapped id
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(32'h400 + 32'(4*i), 5'(i), 1'b1);
      tick();
    end
    #1;
    chk("c_full_ready", bus.disp_ready, 0);
    chk("c_full_count", bus.count, DEPTH);
    bus.cdb_wr = 2'b11; bus.cdb_id = {4'd5, 4'd4}; bus.cdb_wdata = {32'h55, 32'h44};
    tick();
    dispatch(32'h500, 5'd9, 1'b1);
    #1;
    chk("c_full_retire_ready", bus.disp_ready, 0);
    chk("c_full_retire_cmt", bus.cmt_valid, 2'b11);
    tick();
    #1;
    chk("c_count14", bus.count, 14);
    chk("c_wrap_id", bus.disp_id, 4);
    dispatch(32'h504, 5'd9, 1'b1);
    tick();

    // Same-cycle lookup bypass, then stored value
    bus.lk_id = {4'd9, 4'd8};
    bus.cdb_wr = 2'b10; bus.cdb_id = {4'd8, 4'd0}; bus.cdb_wdata = {32'hDEAD, 32'h0};
    #1;
    chk("d_bypass_ready", bus.lk_ready, 2'b01);
    chk("d_bypass_data", bus.lk_wdata, {32'h0, 32'hDEAD});
    tick();
    #1 chk("d_stored_data", bus.lk_wdata, {32'h0, 32'hDEAD});
    tick();

    // Flush with 6 entries and a coincident dispatch
    bus.flush = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      dispatch(32'h600 + 32'(4*i), 5'd1, 1'b1);
      tick();
    end
    bus.flush = 1'b1;
    dispatch(32'h700, 5'd2, 1'b1);
    #1 chk("e_flush_ready", bus.disp_ready, 0);
    tick();
    #1;
    chk("e_count0", bus.count, 0);
    chk("e_empty", bus.empty, 1);
    chk("e_disp_id", bus.disp_id, 0);

`ifdef ROB_MC_EXC_EN
    // Excepting head entry blocks retirement until flush
    dispatch(32'h200, 5'd3, 1'b1);
    tick();
    bus.cdb_wr = 2'b01; bus.cdb_id = '0; bus.cdb_wdata = {32'h0, 32'h77}; bus.cdb_exc = 2'b01;
    tick();
    #1;
    chk("x_cmt_valid", bus.cmt_valid, 0);
    chk("x_exc_req", bus.exc_req, 1);
    chk("x_exc_pc", bus.exc_pc, 32'h200);
    tick();
    bus.flush = 1'b1;
    tick();
    #1 chk("x_exc_clear", bus.exc_req, 0);
`endif

    // Randomized traffic
    bus.lk_id = '0;
    for (int c = 0; c < 600; c++) begin
      bus.disp_valid  = ($urandom_range(0, 3) != 0);
      bus.disp_pc     = $urandom;
      bus.disp_inst   = $urandom;
      bus.disp_has_rd = 1'($urandom_range(0, 1));
      for (int p = 0; p < CDB_N; p++) begin
        int id;
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          id = (head + int'($urandom_range(0, q.size() - 1))) % DEPTH;
        else
          id = int'($urandom_range(0, DEPTH - 1));
        bus.cdb_wr[p] = 1'($urandom_range(0, 1));
        bus.cdb_id[p*PTR_W +: PTR_W] = PTR_W'(id);
        bus.cdb_wdata[p*32 +: 32] = $urandom;
      end
      bus.lk_id = PTR_W*2'($urandom);
      bus.flush = ($urandom_range(0, 63) == 0);
      tick();
    end

    // Asynchronous reset in mid-operation
    for (int i = 0; i < 3; i++) begin
      dispatch(32'h900 + 32'(4*i), 5'd1, 1'b1);
      tick();
    end
    #2 rst = 1'b0;
    #1;
    chk("r_async_count", bus.count, 0);
    chk("r_async_empty", bus.empty, 1);
    chk("r_async_disp_id", bus.disp_id, 0);
    q.delete();
    head = 0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
